// File: rtl/multiciclo_mem_ctrl.sv
// Multicycle load/store controller bridging the CPU to separate code and data RAMs.
// Optional MEMCTRL_MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning them.
module multiciclo_mem_ctrl #(
    parameter int WORD_AW     = 10,
    parameter int WAIT_CYCLES = 1,
    parameter int SEL_BIT     = 28
) (
    input  logic               clockCPU,
    input  logic               reset,
    input  logic               req,
    input  logic               we,
    input  logic [1:0]         size,
    input  logic               uns,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        rdata,
    output logic [WORD_AW-1:0] mem_addr,
    output logic               code_wren,
    output logic               data_wren,
    output logic [3:0]         byteena,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        code_q,
    input  logic [31:0]        data_q
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        uns_q, err_q;
    logic        trap;
    logic [31:0] addr_al;
    logic [31:0] q_sel, q_shift, ld_val;
    logic        unused_addr;

    assign unused_addr = ^addr_q;

    always_comb begin
        addr_al = addr;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
        trap = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
        trap = 1'b0;
        // Round the offending access down to its natural boundary instead of trapping.
        if (size == 2'b01)
            addr_al[0] = 1'b0;
        else if (size[1])
            addr_al[1:0] = 2'b00;
`endif
    end

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && req) begin
                addr_q  <= addr_al;
                wdata_q <= wdata;
                size_q  <= size;
                uns_q   <= uns;
                err_q   <= trap;
            end
            if (state == READ && cnt == LAST)
                rdata <= ld_val;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (req) begin
                    if (trap)
                        state_n = RESP;
                    else if (we)
                        state_n = WRITE;
                    else
                        state_n = READ;
                end
            end
            READ: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // Byte and half lanes share one right shift; half addresses are always even here.
    always_comb begin
        q_sel   = addr_q[SEL_BIT] ? data_q : code_q;
        q_shift = q_sel >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ld_val = {{24{~uns_q & q_shift[7]}}, q_shift[7:0]};
            2'b01:   ld_val = {{16{~uns_q & q_shift[15]}}, q_shift[15:0]};
            default: ld_val = q_sel;
        endcase
    end

    always_comb begin
        byteena = 4'b0000;
        if (state == WRITE) begin
            case (size_q)
                2'b00:   byteena = 4'b0001 << addr_q[1:0];
                2'b01:   byteena = 4'b0011 << {addr_q[1], 1'b0};
                default: byteena = 4'b1111;
            endcase
        end
        case (size_q)
            2'b00:   mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata = {2{wdata_q[15:0]}};
            default: mem_wdata = wdata_q;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == RESP);
    assign err       = (state == RESP) && err_q;
    assign mem_addr  = addr_q[WORD_AW+1:2];
    assign code_wren = (state == WRITE) && !addr_q[SEL_BIT];
    assign data_wren = (state == WRITE) && addr_q[SEL_BIT];

endmodule
